// File: rtl/wordle_round_ctrl_pkg.sv
// Shared encodings for the Wordle round sequencer: cell format, FSM states,
// colour codes and statistics ceiling.
package wordle_round_ctrl_pkg;

   localparam int         CELL_W       = 7;
   localparam logic [6:0] BLANK        = 7'h1A;
   localparam logic [4:0] BLANK_LETTER = 5'd26;
   localparam int         STAT_MAX     = 99;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_SCORE = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      COL_NONE   = 2'b00,
      COL_GREY   = 2'b01,
      COL_YELLOW = 2'b10,
      COL_GREEN  = 2'b11
   } colour_t;

   function automatic logic [6:0] stat_inc(input logic [6:0] v);
      return (int'(v) >= STAT_MAX) ? v : v + 7'd1;
   endfunction

endpackage

// File: rtl/wordle_round_ctrl_if.sv
// Signal bundle between the round sequencer and the selection stage,
// colour evaluator and VGA board.
interface wordle_round_ctrl_if #(
   parameter int ROWS = 6,
   parameter int COLS = 5
);
   import wordle_round_ctrl_pkg::*;

   logic                          start;
   logic                          wr_en;
   logic [2:0]                    wr_col;
   logic [CELL_W-1:0]             wr_val;
   logic                          submit;
   logic [CELL_W*COLS-1:0]        color_row;
   logic                          done_game;
   logic [2:0]                    cur_row;
   logic [CELL_W*COLS-1:0]        cur_row_val;
   logic [CELL_W*COLS*ROWS-1:0]   board_flat;
   logic [6:0]                    word_index;
   state_t                        state;
   logic                          reject;
   logic [6:0]                    games_played;
   logic [6:0]                    games_won;

   modport master (
      output start, wr_en, wr_col, wr_val, submit, color_row, done_game,
      input  cur_row, cur_row_val, board_flat, word_index, state, reject,
             games_played, games_won
   );

   modport slave (
      input  start, wr_en, wr_col, wr_val, submit, color_row, done_game,
      output cur_row, cur_row_val, board_flat, word_index, state, reject,
             games_played, games_won
   );

endinterface

// File: rtl/wordle_round_ctrl_row_full.sv
// Flags a row that still holds at least one blank letter and so cannot be scored.
module wordle_row_full
   import wordle_round_ctrl_pkg::*;
#(
   parameter int COLS = 5
) (
   input  logic [CELL_W*COLS-1:0] row,
   output logic                   any_blank
);

   always_comb begin
      any_blank = 1'b0;
      for (int c = 0; c < COLS; c++) begin
         if (row[CELL_W*c +: 5] == BLANK_LETTER) any_blank = 1'b1;
      end
   end

endmodule

// File: rtl/wordle_round_ctrl.sv
// Wordle game sequencer: owns the letter board, row pointer and word picker,
// and steps each guess through the external colour evaluator.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | word_index free-runs; waiting for start
//  ST_PLAY  | letter writes to current row; submit checks for blanks
//  ST_SCORE | one cycle: latch coloured row, decide win / lose / next row
//  ST_WIN   | hold HOLD_CYCLES with board frozen, then idle
//  ST_LOSE  | hold HOLD_CYCLES with board frozen, then idle
module wordle_round_ctrl
   import wordle_round_ctrl_pkg::*;
#(
   parameter int ROWS        = 6,
   parameter int COLS        = 5,
   parameter int NUM_WORDS   = 100,
   parameter int HOLD_CYCLES = 200
) (
   input  logic               clk,
   input  logic               clr_n,
   wordle_round_ctrl_if.slave bus
);

   localparam int RW = CELL_W*COLS;
   localparam int HW = $clog2(HOLD_CYCLES);

   state_t            state_q, state_d;
   logic [RW-1:0]     board [ROWS];
   logic [2:0]        cur_row_q;
   logic [6:0]        word_index_q;
   logic [HW-1:0]     hold_q;
   logic              reject_q, reject_d;
   logic [6:0]        played_q, won_q;
   logic [RW-1:0]     cur_row_val;
   logic [RW*ROWS-1:0] board_flat;
   logic              row_has_blank;
   logic              do_clear, do_write, do_score, row_inc;
   logic              word_inc, played_inc, won_inc, hold_run, hold_done;

   assign cur_row_val = board[cur_row_q];

   always_comb begin
      board_flat = '0;
      for (int r = 0; r < ROWS; r++) board_flat[r*RW +: RW] = board[r];
   end

   wordle_row_full #(.COLS(COLS)) u_row_full (
      .row       (cur_row_val),
      .any_blank (row_has_blank)
   );

   assign hold_done = (hold_q == HW'(HOLD_CYCLES-1));

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      do_clear   = 1'b0;
      do_write   = 1'b0;
      do_score   = 1'b0;
      row_inc    = 1'b0;
      word_inc   = 1'b0;
      played_inc = 1'b0;
      won_inc    = 1'b0;
      hold_run   = 1'b0;
      reject_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               do_clear   = 1'b1;
               played_inc = 1'b1;
               state_d    = ST_PLAY;
            end else begin
               word_inc = 1'b1;
            end
         end
         ST_PLAY: begin
            // submit wins over a same-cycle write, so it sees the pre-write row
            if (bus.submit) begin
               if (row_has_blank) reject_d = 1'b1;
               else               state_d  = ST_SCORE;
            end else if (bus.wr_en && int'(bus.wr_col) < COLS) begin
               do_write = 1'b1;
            end
         end
         ST_SCORE: begin
            do_score = 1'b1;
            if (bus.done_game) begin
               won_inc = 1'b1;
               state_d = ST_WIN;
            end else if (cur_row_q == 3'(ROWS-1)) begin
               state_d = ST_LOSE;
            end else begin
               row_inc = 1'b1;
               state_d = ST_PLAY;
            end
         end
         ST_WIN, ST_LOSE: begin
            hold_run = 1'b1;
            if (hold_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         for (int r = 0; r < ROWS; r++) board[r] <= {COLS{BLANK}};
      end else begin
         for (int r = 0; r < ROWS; r++) begin
            if (do_clear) begin
               board[r] <= {COLS{BLANK}};
            end else if (cur_row_q == 3'(r)) begin
               if (do_score) begin
                  board[r] <= bus.color_row;
               end else if (do_write) begin
                  for (int c = 0; c < COLS; c++)
                     if (bus.wr_col == 3'(c)) board[r][CELL_W*c +: CELL_W] <= bus.wr_val;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cur_row_q    <= '0;
         word_index_q <= '0;
         hold_q       <= '0;
         reject_q     <= 1'b0;
         played_q     <= '0;
         won_q        <= '0;
      end else begin
         reject_q <= reject_d;
         if (do_clear)     cur_row_q <= '0;
         else if (row_inc) cur_row_q <= cur_row_q + 3'd1;
         if (word_inc)
            word_index_q <= (word_index_q == 7'(NUM_WORDS-1)) ? 7'd0 : word_index_q + 7'd1;
         if (hold_run)
            hold_q <= hold_done ? '0 : hold_q + HW'(1);
         if (played_inc) played_q <= stat_inc(played_q);
         if (won_inc)    won_q    <= stat_inc(won_q);
      end
   end

   assign bus.cur_row      = cur_row_q;
   assign bus.cur_row_val  = cur_row_val;
   assign bus.board_flat   = board_flat;
   assign bus.word_index   = word_index_q;
   assign bus.state        = state_q;
   assign bus.reject       = reject_q;
   assign bus.games_played = played_q;
   assign bus.games_won    = won_q;

endmodule

// File: tb/tb_wordle_round_ctrl.sv
// Scenario bench for the Wordle round sequencer with a board-level reference model.
module tb_wordle_round_ctrl;
   import wordle_round_ctrl_pkg::*;

   localparam int ROWS = 6;
   localparam int COLS = 5;
   localparam int RW   = 7*COLS;
   localparam int HOLD = 200;
   localparam int NW   = 100;

   logic clk   = 1'b0;
   logic clr_n = 1'b0;
   always #5 clk = ~clk;

   wordle_round_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   wordle_round_ctrl #(.ROWS(ROWS), .COLS(COLS), .NUM_WORDS(NW), .HOLD_CYCLES(HOLD)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [6:0] m_board [ROWS][COLS];
   int m_played = 0;
   int m_won    = 0;

   function automatic logic [RW*ROWS-1:0] model_flat();
      logic [RW*ROWS-1:0] f;
      f = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) f[(r*COLS+c)*7 +: 7] = m_board[r][c];
      return f;
   endfunction

   function automatic logic [6:0] rand_letter();
      return {2'($urandom_range(3, 0)), 5'($urandom_range(25, 0))};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.start = 1'b0; bus.wr_en = 1'b0; bus.wr_col = '0; bus.wr_val = '0;
      bus.submit = 1'b0; bus.color_row = '0; bus.done_game = 1'b0;
   endtask

   task automatic model_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) m_board[r][c] = 7'h1A;
   endtask

   task automatic do_reset();
      clear_inputs();
      clr_n = 1'b0;
      tick(); tick();
      clr_n = 1'b1;
      model_clear();
      m_played = 0;
      m_won    = 0;
   endtask

   task automatic start_game();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      model_clear();
      if (m_played < 99) m_played++;
   endtask

   task automatic fill_row(input int r);
      logic [6:0] v;
      for (int c = 0; c < COLS; c++) begin
         v = rand_letter();
         bus.wr_en = 1'b1; bus.wr_col = 3'(c); bus.wr_val = v;
         tick();
         m_board[r][c] = v;
      end
      bus.wr_en = 1'b0;
   endtask

   // Submits a full row, supplies the evaluator result and waits through SCORE.
   task automatic score_row(input int r, input logic done, output logic [RW-1:0] col);
      col = RW'({$urandom(), $urandom()});
      bus.color_row = col; bus.done_game = done; bus.submit = 1'b1;
      tick();
      bus.submit = 1'b0;
      tick();
      bus.done_game = 1'b0;
      for (int c = 0; c < COLS; c++) m_board[r][c] = col[c*7 +: 7];
      if (done && m_won < 99) m_won++;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", bus.state, ST_IDLE); end
      checks++; if (bus.cur_row !== 3'd0) begin errors++; $display("FAIL reset_cur_row: got %0d expected 0", bus.cur_row); end
      checks++; if (bus.word_index !== 7'd0) begin errors++; $display("FAIL reset_word_index: got %0d expected 0", bus.word_index); end
      checks++; if (bus.reject !== 1'b0) begin errors++; $display("FAIL reset_reject: got %0b expected 0", bus.reject); end
      checks++; if (bus.games_played !== 7'd0 || bus.games_won !== 7'd0) begin errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", bus.games_played, bus.games_won); end
      checks++; if (bus.board_flat !== model_flat()) begin errors++; $display("FAIL reset_board: got %h expected %h", bus.board_flat, model_flat()); end
   endtask

   task automatic test_start();
      int n;
      do_reset();
      repeat (5) tick();
      start_game();
      checks++; if (bus.state !== ST_PLAY) begin errors++; $display("FAIL start_state: got %0d expected %0d", bus.state, ST_PLAY); end
      checks++; if (bus.word_index !== 7'd5) begin errors++; $display("FAIL start_word_index: got %0d expected 5", bus.word_index); end
      checks++; if (bus.board_flat !== model_flat()) begin errors++; $display("FAIL start_board: got %h expected %h", bus.board_flat, model_flat()); end
      checks++; if (bus.games_played !== 7'(m_played)) begin errors++; $display("FAIL start_played: got %0d expected %0d", bus.games_played, m_played); end
      n = $urandom_range(30, 2);
      repeat (n) tick();
      checks++; if (bus.word_index !== 7'd5) begin errors++; $display("FAIL play_word_frozen: got %0d expected 5", bus.word_index); end
   endtask

   task automatic test_idle_wrap();
      int k;
      do_reset();
      repeat (99) tick();
      checks++; if (bus.word_index !== 7'd99) begin errors++; $display("FAIL idle_99: got %0d expected 99", bus.word_index); end
      tick();
      checks++; if (bus.word_index !== 7'd0) begin errors++; $display("FAIL idle_wrap: got %0d expected 0", bus.word_index); end
      k = $urandom_range(150, 1);
      repeat (k) tick();
      checks++; if (bus.word_index !== 7'(k % NW)) begin errors++; $display("FAIL idle_random: got %0d expected %0d", bus.word_index, k % NW); end
   endtask

   task automatic test_reject_and_same_cycle();
      logic [RW-1:0] col;
      logic [6:0]    v;
      start_game();
      for (int c = 0; c < 4; c++) begin
         v = rand_letter();
         bus.wr_en = 1'b1; bus.wr_col = 3'(c); bus.wr_val = v;
         tick();
         m_board[0][c] = v;
      end
      bus.wr_col = 3'($urandom_range(7, 5)); bus.wr_val = rand_letter();
      tick();
      bus.wr_en = 1'b0;
      checks++; if (bus.board_flat !== model_flat()) begin errors++; $display("FAIL write_partial: got %h expected %h", bus.board_flat, model_flat()); end
      bus.submit = 1'b1;
      tick();
      bus.submit = 1'b0;
      checks++; if (bus.reject !== 1'b1) begin errors++; $display("FAIL reject_pulse: got %0b expected 1", bus.reject); end
      checks++; if (bus.state !== ST_PLAY || bus.cur_row !== 3'd0) begin errors++; $display("FAIL reject_stay: got state %0d row %0d expected 1 0", bus.state, bus.cur_row); end
      tick();
      checks++; if (bus.reject !== 1'b0) begin errors++; $display("FAIL reject_one_cycle: got %0b expected 0", bus.reject); end
      // write to the blank cell together with submit: still rejected, write dropped
      bus.submit = 1'b1; bus.wr_en = 1'b1; bus.wr_col = 3'd4; bus.wr_val = rand_letter();
      tick();
      bus.submit = 1'b0; bus.wr_en = 1'b0;
      checks++; if (bus.reject !== 1'b1 || bus.board_flat !== model_flat()) begin errors++; $display("FAIL same_cycle_blank: got reject %0b board %h expected 1 %h", bus.reject, bus.board_flat, model_flat()); end
      v = rand_letter();
      bus.wr_en = 1'b1; bus.wr_col = 3'd4; bus.wr_val = v;
      tick();
      bus.wr_en = 1'b0;
      m_board[0][4] = v;
      col = RW'({$urandom(), $urandom()});
      bus.submit = 1'b1; bus.wr_en = 1'b1; bus.wr_col = 3'd0; bus.wr_val = rand_letter();
      bus.color_row = col; bus.done_game = 1'b0;
      tick();
      bus.submit = 1'b0; bus.wr_en = 1'b0;
      checks++; if (bus.state !== ST_SCORE || bus.board_flat !== model_flat()) begin errors++; $display("FAIL same_cycle_full: got state %0d board %h expected 2 %h", bus.state, bus.board_flat, model_flat()); end
      tick();
      for (int c = 0; c < COLS; c++) m_board[0][c] = col[c*7 +: 7];
      checks++; if (bus.state !== ST_PLAY || bus.cur_row !== 3'd1 || bus.board_flat !== model_flat()) begin errors++; $display("FAIL score_next_row: got state %0d row %0d board %h expected 1 1 %h", bus.state, bus.cur_row, bus.board_flat, model_flat()); end
   endtask

   task automatic test_reset_mid_score();
      fill_row(1);
      bus.color_row = RW'({$urandom(), $urandom()}); bus.submit = 1'b1;
      tick();
      bus.submit = 1'b0;
      checks++; if (bus.state !== ST_SCORE) begin errors++; $display("FAIL mid_score_entry: got %0d expected %0d", bus.state, ST_SCORE); end
      clr_n = 1'b0;
      #2;
      model_clear();
      checks++; if (bus.state !== ST_IDLE || bus.cur_row !== 3'd0 || bus.word_index !== 7'd0 || bus.reject !== 1'b0) begin errors++; $display("FAIL mid_score_regs: got state %0d row %0d idx %0d rej %0b expected 0 0 0 0", bus.state, bus.cur_row, bus.word_index, bus.reject); end
      checks++; if (bus.games_played !== 7'd0 || bus.board_flat !== model_flat()) begin errors++; $display("FAIL mid_score_board: got played %0d board %h expected 0 %h", bus.games_played, bus.board_flat, model_flat()); end
      tick();
      clr_n = 1'b1;
      clear_inputs();
      m_played = 0;
      m_won    = 0;
   endtask

   task automatic test_lose();
      logic [RW-1:0]      col;
      logic [RW*ROWS-1:0] snap;
      int n;
      do_reset();
      n = $urandom_range(250, 1);
      repeat (n) tick();
      start_game();
      for (int r = 0; r < ROWS; r++) begin
         fill_row(r);
         score_row(r, 1'b0, col);
         checks++; if (bus.board_flat !== model_flat()) begin errors++; $display("FAIL lose_row%0d_board: got %h expected %h", r, bus.board_flat, model_flat()); end
         if (r < ROWS-1) begin
            checks++; if (bus.state !== ST_PLAY || bus.cur_row !== 3'(r+1)) begin errors++; $display("FAIL lose_row%0d_adv: got state %0d row %0d expected 1 %0d", r, bus.state, bus.cur_row, r+1); end
         end
      end
      checks++; if (bus.state !== ST_LOSE || bus.cur_row !== 3'd5) begin errors++; $display("FAIL lose_entry: got state %0d row %0d expected 4 5", bus.state, bus.cur_row); end
      snap = model_flat();
      for (int i = 0; i < HOLD-1; i++) begin
         bus.start = 1'($urandom_range(1, 0)); bus.submit = 1'($urandom_range(1, 0));
         bus.wr_en = 1'b1; bus.wr_col = 3'($urandom_range(4, 0)); bus.wr_val = rand_letter();
         bus.done_game = 1'($urandom_range(1, 0));
         tick();
      end
      clear_inputs();
      checks++; if (bus.state !== ST_LOSE || bus.board_flat !== snap) begin errors++; $display("FAIL lose_hold: got state %0d board %h expected 4 %h", bus.state, bus.board_flat, snap); end
      checks++; if (bus.word_index !== 7'(n % NW)) begin errors++; $display("FAIL lose_word_stable: got %0d expected %0d", bus.word_index, n % NW); end
      tick();
      checks++; if (bus.state !== ST_IDLE || bus.games_won !== 7'd0 || bus.games_played !== 7'd1) begin errors++; $display("FAIL lose_exit: got state %0d won %0d played %0d expected 0 0 1", bus.state, bus.games_won, bus.games_played); end
      tick();
      checks++; if (bus.word_index !== 7'((n+1) % NW) || bus.board_flat !== snap) begin errors++; $display("FAIL idle_after_lose: got idx %0d expected %0d", bus.word_index, (n+1) % NW); end
   endtask

   task automatic test_win();
      logic [RW-1:0] col;
      start_game();
      fill_row(0);
      score_row(0, 1'b1, col);
      checks++; if (bus.cur_row_val !== col || bus.board_flat !== model_flat()) begin errors++; $display("FAIL win_row0: got %h expected %h", bus.cur_row_val, col); end
      checks++; if (bus.state !== ST_WIN || bus.cur_row !== 3'd0) begin errors++; $display("FAIL win_state: got state %0d row %0d expected 3 0", bus.state, bus.cur_row); end
      checks++; if (bus.games_won !== 7'(m_won) || bus.games_played !== 7'(m_played)) begin errors++; $display("FAIL win_stats: got %0d/%0d expected %0d/%0d", bus.games_won, bus.games_played, m_won, m_played); end
      repeat (HOLD-1) tick();
      checks++; if (bus.state !== ST_WIN) begin errors++; $display("FAIL win_hold: got %0d expected %0d", bus.state, ST_WIN); end
      tick();
      checks++; if (bus.state !== ST_IDLE || bus.board_flat !== model_flat()) begin errors++; $display("FAIL win_exit: got state %0d board %h expected 0 %h", bus.state, bus.board_flat, model_flat()); end
   endtask

   task automatic test_saturation();
      logic [RW-1:0] col;
      for (int g = 0; g < 100; g++) begin
         start_game();
         fill_row(0);
         score_row(0, 1'b1, col);
         repeat (HOLD) tick();
      end
      checks++; if (bus.games_played !== 7'(m_played) || bus.games_won !== 7'(m_won)) begin errors++; $display("FAIL stat_saturate: got %0d/%0d expected %0d/%0d", bus.games_played, bus.games_won, m_played, m_won); end
      checks++; if (bus.state !== ST_IDLE) begin errors++; $display("FAIL stat_final_state: got %0d expected 0", bus.state); end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      test_reset();
      test_start();
      test_idle_wrap();
      test_reject_and_same_cycle();
      test_reset_mid_score();
      test_lose();
      test_win();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
